// File: rtl/ring_pkg.sv
// ring_pkg: shared constants, width helper and result record for the ring collector
package ring_pkg;
  function automatic int bits_for(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int RING_WIDTH = 16;
  localparam int RING_PERIOD = 4;
  localparam int RING_ROWS = 4;
  localparam int ROW_W = bits_for(RING_ROWS);
  typedef struct packed {
    logic [RING_WIDTH-1:0] data;
    logic [ROW_W-1:0] row;
    logic last;
  } result_t;
endpackage

// File: rtl/ring_result_collector_if.sv
// ring_result_collector_if: valid/ready result stream towards the next consumer
interface ring_result_collector_if;
  import ring_pkg::*;
  logic valid;
  logic ready;
  logic [RING_WIDTH-1:0] data;
  logic [ROW_W-1:0] row;
  logic last;
  modport master(output valid, data, row, last, input ready);
  modport slave(input valid, data, row, last, output ready);
endinterface

// File: rtl/ring_result_fifo.sv
// ring_result_fifo: synchronous FIFO of result_t, head entry presented combinationally
module ring_result_fifo
  import ring_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  result_t din,
  output result_t dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  result_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  // a pop frees the slot a simultaneous push needs when full
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ring_result_collector.sv
// ring_result_collector: samples PE results on period boundaries and buffers them with row tags
module ring_result_collector
  import ring_pkg::*;
#(
  parameter int WIDTH = RING_WIDTH,
  parameter int PERIOD = RING_PERIOD,
  parameter int ROWS = RING_ROWS,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic [WIDTH-1:0] y,
  ring_result_collector_if.master out,
  output logic overflow,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = bits_for(PERIOD);
  logic [PW-1:0] phase;
  logic primed, cap, pop, full, empty;
  logic [ROW_W-1:0] row;
  result_t entry, head;
  assign cap = primed && phase == '0;
  assign pop = out.valid && out.ready;
  assign entry = '{data: RING_WIDTH'(y), row: row, last: row == ROW_W'(ROWS - 1)};
  assign out.valid = !empty;
  assign out.data = head.data;
  assign out.row = head.row;
  assign out.last = head.last;
  ring_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(cap),
    .pop(pop),
    .din(entry),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // phase mirrors the PE counter; primed gates off the partial first period
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
      primed <= 1'b0;
      row <= '0;
      overflow <= 1'b0;
    end else begin
      phase <= phase + 1'b1;
      if (phase == PW'(PERIOD - 1)) primed <= 1'b1;
      if (cap) row <= row == ROW_W'(ROWS - 1) ? '0 : row + 1'b1;
      if (cap && full && !pop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ring_result_collector.sv
// tb_ring_result_collector: directed checks of capture timing, buffering, overflow and reset
module tb_ring_result_collector;
  import ring_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic use_pe = 1'b0;
  logic ramp = 1'b0;
  logic [15:0] y;
  logic [15:0] y_drv = 16'hDEAD;
  logic [15:0] pe_y, pe_acc, pe_snap;
  logic [1:0] pe_phase;
  logic overflow;
  logic [2:0] count;
  int edge_n = 0;
  int checks = 0;
  int failures = 0;

  ring_result_collector_if bus ();
  ring_result_collector dut (
    .clk(clk),
    .reset(reset),
    .y(y),
    .out(bus),
    .overflow(overflow),
    .count(count)
  );

  always #5 clk = ~clk;

  // reference PE: x_init=3, x=1, a=1; result = 3 + 4*1 = 7 published each period
  always_ff @(posedge clk) begin
    if (reset) begin
      pe_phase <= 2'd0;
      pe_acc <= 16'h0003;
      pe_y <= 16'h0000;
    end else begin
      pe_phase <= pe_phase + 2'd1;
      if (pe_phase == 2'd3) begin
        pe_y <= pe_acc + 16'h0001;
        pe_acc <= 16'h0003;
      end else begin
        pe_y <= 16'h0001;
        pe_acc <= pe_acc + 16'h0001;
      end
    end
  end

  assign y = use_pe ? pe_y : y_drv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // value on y during the cycle after edge edge_n, i.e. what edge edge_n+1 sees
  task automatic set_y();
    if (ramp) y_drv = 16'h0100 + 16'(edge_n);
    else if (edge_n >= 4 && edge_n % 4 == 0) y_drv = 16'h0A0A + 16'(edge_n / 4 - 1);
    else y_drv = 16'hDEAD;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    set_y();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    edge_n = 0;
    set_y();
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) tick();
  endtask

  initial begin
    bus.ready = 1'b0;
    do_reset();
    chk("rst_valid", bus.valid, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_row", bus.row, 0);
    chk("rst_last", bus.last, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_count", count, 0);

    // ramp stream, consumer always ready
    ramp = 1'b1;
    bus.ready = 1'b1;
    do_reset();
    for (int e = 1; e <= 18; e++) begin
      tick();
      if (e > 1 && e % 4 == 1) begin
        chk($sformatf("ramp_valid_e%0d", e), bus.valid, 1);
        chk($sformatf("ramp_data_e%0d", e), bus.data, 32'h0100 + e - 1);
        chk($sformatf("ramp_row_e%0d", e), bus.row, e / 4 - 1);
        chk($sformatf("ramp_last_e%0d", e), bus.last, (e == 17) ? 1 : 0);
      end else begin
        chk($sformatf("ramp_idle_e%0d", e), bus.valid, 0);
      end
    end

    // overflow: consumer stalled for five periods
    ramp = 1'b0;
    bus.ready = 1'b0;
    do_reset();
    run_to(5);
    chk("ovf_first_data", bus.data, 32'h0A0A);
    for (int e = 6; e <= 8; e++) begin
      tick();
      chk($sformatf("hold_data_e%0d", e), bus.data, 32'h0A0A);
      chk($sformatf("hold_row_e%0d", e), bus.row, 0);
      chk($sformatf("hold_last_e%0d", e), bus.last, 0);
    end
    run_to(17);
    chk("ovf_count_full", count, 4);
    chk("ovf_not_yet", overflow, 0);
    run_to(21);
    chk("ovf_count_after_drop", count, 4);
    chk("ovf_set", overflow, 1);
    chk("ovf_head_kept", bus.data, 32'h0A0A);
    bus.ready = 1'b1;
    tick();
    chk("drain_1", bus.data, 32'h0A0B);
    tick();
    chk("drain_2", bus.data, 32'h0A0C);
    tick();
    chk("drain_3", bus.data, 32'h0A0D);
    chk("drain_3_row", bus.row, 3);
    chk("drain_3_last", bus.last, 1);
    tick();
    chk("after_drop_count", count, 1);
    chk("after_drop_data", bus.data, 32'h0A0F);
    chk("after_drop_row", bus.row, 1);
    chk("ovf_sticky", overflow, 1);

    // full FIFO with pop exactly on the capture edge
    bus.ready = 1'b0;
    do_reset();
    run_to(17);
    chk("fullpop_pre_count", count, 4);
    run_to(20);
    bus.ready = 1'b1;
    tick();
    chk("fullpop_count", count, 4);
    chk("fullpop_ovf", overflow, 0);
    chk("fullpop_head", bus.data, 32'h0A0B);
    tick();
    chk("fullpop_d2", bus.data, 32'h0A0C);
    tick();
    chk("fullpop_d3", bus.data, 32'h0A0D);
    tick();
    chk("fullpop_tail", bus.data, 32'h0A0E);
    chk("fullpop_tail_row", bus.row, 0);
    chk("fullpop_tail_last", bus.last, 0);
    chk("fullpop_tail_count", count, 1);

    // reset at phase 2 with two entries buffered
    bus.ready = 1'b0;
    do_reset();
    run_to(10);
    chk("midrst_pre_count", count, 2);
    chk("midrst_pre_valid", bus.valid, 1);
    do_reset();
    chk("midrst_valid", bus.valid, 0);
    chk("midrst_count", count, 0);
    run_to(4);
    chk("midrst_no_early", count, 0);
    tick();
    chk("midrst_cap_count", count, 1);
    chk("midrst_cap_data", bus.data, 32'h0A0A);
    chk("midrst_cap_row", bus.row, 0);

    // integration with the reference PE
    use_pe = 1'b1;
    bus.ready = 1'b1;
    do_reset();
    run_to(4);
    pe_snap = pe_y;
    chk("pe_result", pe_snap, 32'h0007);
    tick();
    chk("pe_cap_valid", bus.valid, 1);
    chk("pe_cap_match", bus.data, pe_snap);
    for (int e = 6; e <= 13; e++) begin
      tick();
      if (e % 4 == 1) chk($sformatf("pe_period_e%0d", e), bus.data, 32'h0007);
      else chk($sformatf("pe_idle_e%0d", e), bus.valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
